// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU: op codes, FSM states, SUB carry-in.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic SUB_CIN = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // SUB and SLT both evaluate a + ~b + 1
  function automatic logic inv_b(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU slice used once per cycle by alu_serial_ctrl.
module alu_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       out,
  output logic       cout
);

  logic w_b;

  assign w_b = b ^ inv_b(op);

  always_comb begin
    out  = 1'b0;
    cout = 1'b0;
    unique case (1'b1)
      (op == OP_AND): out = a & b;
      (op == OP_OR):  out = a | b;
      (op == OP_ADD),
      (op == OP_SUB),
      (op == OP_SLT): begin
        out  = a ^ w_b ^ cin;
        cout = (a & w_b) | (a & cin) | (w_b & cin);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: one result bit per cycle, LSB first.
// Status flags are built only when ALU_SERIAL_FLAGS_EN is defined.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_res;

  logic             w_out;
  logic             w_cout;
  logic             w_last;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res_nxt;

  alu_slice u_slice (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .op   (r_op),
    .out  (w_out),
    .cout (w_cout)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_ovf  = r_carry ^ w_cout;

  // On the last SLT bit the shifted sum is replaced by the less-than bit
  always_comb begin
    w_res_nxt = {w_out, r_res[WIDTH-1:1]};
    if (w_last && (r_op == OP_SLT))
      w_res_nxt = {{(WIDTH-1){1'b0}}, w_out ^ w_ovf};
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (in_valid)  w_state_nxt = RUN;
      RUN:  if (w_last)    w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default:             w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= b;
          r_op    <= op;
          r_cnt   <= '0;
          r_carry <= inv_b(op) ? SUB_CIN : 1'b0;
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + CW'(1);
          r_carry <= w_cout;
          r_res   <= w_res_nxt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_res;

`ifdef ALU_SERIAL_FLAGS_EN
  logic r_fz;
  logic r_fc;
  logic r_fo;
  logic w_arith;

  assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fz <= 1'b0;
      r_fc <= 1'b0;
      r_fo <= 1'b0;
    end else if ((r_state == IDLE) && in_valid) begin
      r_fz <= 1'b0;
      r_fc <= 1'b0;
      r_fo <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_fz <= (w_res_nxt == '0);
      r_fc <= w_arith & w_cout;
      r_fo <= w_arith & w_ovf;
    end
  end

  assign flag_zero  = r_fz;
  assign flag_carry = r_fc;
  assign flag_ovf   = r_fo;
`else
  assign flag_zero  = 1'b0;
  assign flag_carry = 1'b0;
  assign flag_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=8) against an arithmetic model.
module tb_alu_serial_ctrl;

  localparam int W = 8;

`ifdef ALU_SERIAL_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, carry, zero, result}.
  function automatic logic [10:0] model(input int ia, input int ib,
                                        input logic [2:0] iop);
    int r, c, o, sa, sb, s;
    r = 0; c = 0; o = 0;
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    case (iop)
      3'b000: r = ia & ib;
      3'b001: r = ia | ib;
      3'b010: begin
        s = ia + ib;
        r = s % 256; c = s / 256;
        o = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0;
      end
      3'b110: begin
        r = (ia - ib + 256) % 256;
        c = (ia >= ib) ? 1 : 0;
        o = ((sa - sb) > 127 || (sa - sb) < -128) ? 1 : 0;
      end
      3'b111: r = (sa < sb) ? 1 : 0;
      default: r = 0;
    endcase
    if (!FLAGS_ON) begin c = 0; o = 0; end
    model = {o[0], c[0], FLAGS_ON && (r == 0), r[7:0]};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [2:0] top, input int hold,
                        input bit poke);
    logic [10:0] e;
    int n;
    e = model(int'(ta), int'(tb), top);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; a = ta; b = tb; op = top;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom);
    chk("in_ready_run", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, W);
    chk("result", result, e[7:0]);
    chk("zero", flag_zero, e[8]);
    chk("carry", flag_carry, e[9]);
    chk("ovf", flag_ovf, e[10]);
    chk("in_ready_done", in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      if (poke) in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_result", result, e[7:0]);
      chk("hold_flags", {flag_ovf, flag_carry, flag_zero}, e[10:8]);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_ovf, flag_carry, flag_zero}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h7F, 8'h01, 3'b010, 0, 0);
    run_op(8'h00, 8'h01, 3'b110, 0, 0);
    run_op(8'h05, 8'h05, 3'b110, 0, 0);
    run_op(8'hFE, 8'h01, 3'b111, 0, 0);
    run_op(8'h01, 8'hFE, 3'b111, 0, 0);
    run_op(8'hF0, 8'h3C, 3'b000, 0, 0);
    run_op(8'hF0, 8'h3C, 3'b001, 0, 0);
    run_op(8'hA5, 8'h5A, 3'b011, 0, 0);
    run_op(8'h80, 8'h80, 3'b010, 0, 0);
    run_op(8'h80, 8'h01, 3'b110, 0, 0);
    run_op(8'h12, 8'h34, 3'b010, 5, 1);

    // Reset during the third RUN cycle
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'b010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_flags", {flag_ovf, flag_carry, flag_zero}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h01, 8'h02, 3'b010, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] rop;
      case ($urandom_range(0, 6))
        0: rop = 3'b000;
        1: rop = 3'b001;
        2: rop = 3'b010;
        3: rop = 3'b110;
        4: rop = 3'b111;
        5: rop = 3'b010;
        default: rop = 3'($urandom);
      endcase
      run_op(W'($urandom), W'($urandom), rop,
             $urandom_range(0, 3), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
